mux_thicc: RTL and testbench

- 16:1 multiplexer of WIDTH-bit words, selected by a 4-bit code; used as the register-file read port and general datapath selector.
- Primary output `out` is purely combinational and needs no clock.
- Secondary registered copy (`out_q`, `sel_q`) is loaded on `clk` under an enable, for pipelined consumers.

---
 rtl/mux_thicc.sv | 100 ++++++++++
 tb/tb_mux_thicc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_thicc.sv
// ==========================================================================
// mux_thicc : 16:1 WIDTH-bit selector with enabled registered copy.
// Optional parity flop enabled by defining MUX_THICC_PARITY_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module mux_thicc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  input  logic [WIDTH-1:0] in_8,
  input  logic [WIDTH-1:0] in_9,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_f,
  input  logic [3:0]       select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       sel_q,
  output logic             par_q
);

  logic [WIDTH-1:0] out_d;
  logic [3:0]       sel_d;

  // Unmatched (X/Z) select falls to the default, giving zeros rather than a latch.
  always_comb begin
    out = '0;
    case (select)
      4'h0: out = in_0;
      4'h1: out = in_1;
      4'h2: out = in_2;
      4'h3: out = in_3;
      4'h4: out = in_4;
      4'h5: out = in_5;
      4'h6: out = in_6;
      4'h7: out = in_7;
      4'h8: out = in_8;
      4'h9: out = in_9;
      4'ha: out = in_a;
      4'hb: out = in_b;
      4'hc: out = in_c;
      4'hd: out = in_d;
      4'he: out = in_e;
      4'hf: out = in_f;
      default: out = '0;
    endcase
  end

  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    if (en) begin
      out_d = out;
      sel_d = select;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= '0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX_THICC_PARITY_EN
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (en) par_d = ^out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`else
  assign par_q = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_thicc.sv
// ==========================================================================
// tb_mux_thicc : directed plus randomized self-checking bench for mux_thicc.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mux_thicc;

  localparam int WIDTH = 8;

  logic             clk;
  logic             clk_run;
  logic             rst_n;
  logic [WIDTH-1:0] din [16];
  logic [3:0]       select;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [3:0]       sel_q;
  logic             par_q;

  int checks = 0;
  int errors = 0;

  // Reference state for the registered path.
  logic [WIDTH-1:0] m_out_q;
  logic [3:0]       m_sel_q;
  logic             m_par_q;

  mux_thicc #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_0   (din[0]),
    .in_1   (din[1]),
    .in_2   (din[2]),
    .in_3   (din[3]),
    .in_4   (din[4]),
    .in_5   (din[5]),
    .in_6   (din[6]),
    .in_7   (din[7]),
    .in_8   (din[8]),
    .in_9   (din[9]),
    .in_a   (din[10]),
    .in_b   (din[11]),
    .in_c   (din[12]),
    .in_d   (din[13]),
    .in_e   (din[14]),
    .in_f   (din[15]),
    .select (select),
    .en     (en),
    .out    (out),
    .out_q  (out_q),
    .sel_q  (sel_q),
    .par_q  (par_q)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] v);
`ifdef MUX_THICC_PARITY_EN
    int ones = 0;
    for (int b = 0; b < WIDTH; b++) ones += int'(v[b]);
    return logic'(ones % 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, 32'(out_q), 32'(m_out_q));
    check({tag, ".sel_q"}, 32'(sel_q), 32'(m_sel_q));
    check({tag, ".par_q"}, 32'(par_q), 32'(m_par_q));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clk_run = 1'b0;
    rst_n   = 1'b0;
    en      = 1'b0;
    select  = 4'h0;
    for (int i = 0; i < 16; i++) din[i] = '0;
    din[1] = 8'h11; din[2] = 8'h12; din[3] = 8'h13; din[15] = 8'h1F;
    m_out_q = '0; m_sel_q = '0; m_par_q = 1'b0;

    // Combinational path with no clock, in reset.
    select = 4'h0; #10 check("comb_sel0", 32'(out), 32'h00);
    select = 4'h1; #10 check("comb_sel1", 32'(out), 32'h11);
    select = 4'h3; #10 check("comb_sel3", 32'(out), 32'h13);
    select = 4'hF; #10 check("comb_selF", 32'(out), 32'h1F);
    select = 4'h3; #10 check("rst_out",   32'(out), 32'h13);
    check_regs("rst");

    // First load.
    rst_n = 1'b1; en = 1'b1; select = 4'hF;
    #10;
    clk_run = 1'b1;
    @(posedge clk); #1;
    m_out_q = 8'h1F; m_sel_q = 4'hF; m_par_q = exp_par(8'h1F);
    check_regs("load");
`ifdef MUX_THICC_PARITY_EN
    check("load.par_const", 32'(par_q), 32'h1);
`endif

    // Hold with en low.
    @(negedge clk);
    en = 1'b0; select = 4'h2;
    #1 check("hold_out", 32'(out), 32'h12);
    @(posedge clk); @(posedge clk); #1;
    check_regs("hold");

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    m_out_q = '0; m_sel_q = '0; m_par_q = 1'b0;
    check_regs("async_rst");
    #1 rst_n = 1'b1;

    // Exhaustive sweep with en high.
    for (int i = 0; i < 16; i++) din[i] = 8'(8'hA0 + i);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        m_out_q = 8'(8'hA0 + i - 1); m_sel_q = 4'(i - 1); m_par_q = exp_par(m_out_q);
        check_regs("sweep");
      end
      select = 4'(i);
      #1 check("sweep_out", 32'(out), 32'(8'hA0 + i));
    end
    @(posedge clk);
    m_out_q = 8'hAF; m_sel_q = 4'hF; m_par_q = exp_par(8'hAF);
    @(negedge clk);
    check_regs("sweep_last");

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 16; i++) din[i] = 8'($urandom);
      select = 4'($urandom_range(0, 15));
      en     = 1'($urandom);
      rst_n  = ($urandom_range(0, 19) != 0);
      if (!rst_n) begin
        m_out_q = '0; m_sel_q = '0; m_par_q = 1'b0;
      end
      #1;
      check("rand_out", 32'(out), 32'(din[select]));
      check_regs("rand_pre");
      @(posedge clk);
      if (rst_n && en) begin
        m_out_q = din[select];
        m_sel_q = select;
        m_par_q = exp_par(din[select]);
      end
      @(negedge clk);
      check_regs("rand_post");
    end

    clk_run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
